// File: rtl/run_ctrl.sv
// Run controller: sequences a core through hold/run/finish and arbitrates the data memory between host and core.
// Optional watchdog abort is compiled in with `define RUN_CTRL_WDOG_EN.
module run_ctrl #(
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] WDOG_MAX   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        host_wr_en,
  input  logic        host_rd_en,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_nack,
  input  logic        core_wr_en,
  input  logic [7:0]  core_addr,
  input  logic [7:0]  core_wdata,
  input  logic        core_done,
  output logic        core_start,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        run_done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, PRERST, RUN, FINISH} state_t;

  localparam logic [15:0] HOLD_INIT = 16'(RST_CYCLES);
`ifdef RUN_CTRL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  state_t      state;
  logic [15:0] hold;
  logic [15:0] cnt_next;
  logic        wdog_hit;
  logic        host_owns;

  assign cnt_next  = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
  assign wdog_hit  = ({1'b0, cycle_count} + 17'd1) == {1'b0, WDOG_MAX};
  assign host_owns = (state == IDLE) || (state == FINISH);

  // core_start and busy are registered alongside the state so they never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      cycle_count <= '0;
      run_done    <= 1'b0;
      timeout     <= 1'b0;
      core_start  <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (go) begin
            state       <= PRERST;
            hold        <= HOLD_INIT;
            cycle_count <= '0;
            run_done    <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            core_start  <= 1'b1;
          end
        end
        PRERST: begin
          hold <= (hold == 16'd0) ? 16'd0 : hold - 16'd1;
          // a zero load still yields one hold cycle
          if (hold <= 16'd1) begin
            state      <= RUN;
            core_start <= 1'b0;
          end
        end
        RUN: begin
          cycle_count <= cnt_next;
          if (core_done) begin
            state      <= FINISH;
            run_done   <= 1'b1;
            core_start <= 1'b1;
            busy       <= 1'b0;
          end else if (WDOG_EN && wdog_hit) begin
            state      <= FINISH;
            timeout    <= 1'b1;
            core_start <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_start <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (state == RUN) begin
      mem_wr_en = core_wr_en;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_owns) begin
      mem_wr_en = host_wr_en;
    end
  end

  assign host_rdata = host_owns ? mem_rdata : 8'h00;
  assign host_nack  = !host_owns && (host_wr_en || host_rd_en);

endmodule
